// File: rtl/serial_add32_ctrl_pkg.sv
// Shared definitions for the byte-serial adder controller.
//   SLICE_W : width of the shared adder slice (one byte).
//   state_t : controller states IDLE / RUN / DONE.
package serial_add32_ctrl_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add32_ctrl_add8_slice.sv
// add8_slice: combinational byte adder shared by every byte of the operands.
// Ports:
//   a, b : byte operands
//   ci   : carry-in
//   s    : byte sum
//   co   : carry-out
module add8_slice
  import serial_add32_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/serial_add32_ctrl.sv
// serial_add32_ctrl: adds two W-bit operands one byte per cycle through a
// single shared byte adder, LSB byte first.
// Optional feature: define SERIAL_SUB_EN to add the 'sub' port, which
// computes a-b (b inverted per byte, initial carry-in 1; co=1 means no borrow).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : request; only sampled while idle
//   sub        : subtract request (SERIAL_SUB_EN only)
//   a, b       : operands, latched on acceptance
//   busy       : high in RUN and DONE
//   done       : one-cycle result-valid pulse
//   sum, co    : result and final carry, held until next accepted start
module serial_add32_ctrl
  import serial_add32_ctrl_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = SLICE_W * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t                            state, state_nx;
  logic   [CNT_W-1:0]                cnt;
  logic                              carry;
  logic                              co_r;
  logic   [NBYTES-1:0][SLICE_W-1:0]  a_r, b_r, sum_r;
  logic   [SLICE_W-1:0]              s_b, s_sum;
  logic                              s_co;
  logic                              cin0;
  logic                              accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CNT_W'(NBYTES - 1));

`ifdef SERIAL_SUB_EN
  logic sub_r;

  always_ff @(posedge clk) begin
    if (reset)       sub_r <= 1'b0;
    else if (accept) sub_r <= sub;
  end

  // Two's-complement subtract: a + ~b + 1, the +1 entering as initial carry.
  assign s_b  = b_r[cnt] ^ {SLICE_W{sub_r}};
  assign cin0 = sub;
`else
  assign s_b  = b_r[cnt];
  assign cin0 = 1'b0;
`endif

  add8_slice u_slice (
    .a  (a_r[cnt]),
    .b  (s_b),
    .ci (carry),
    .s  (s_sum),
    .co (s_co)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      co_r  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      sum_r <= '0;
      cnt   <= '0;
      carry <= cin0;
      co_r  <= 1'b0;
    end else if (state == RUN) begin
      sum_r[cnt] <= s_sum;
      carry      <= s_co;
      // Counter parks on the last byte instead of wrapping.
      if (last) co_r <= s_co;
      else      cnt  <= cnt + 1'b1;
    end
  end

  assign sum = sum_r;
  assign co  = co_r;

endmodule

// File: tb/tb_serial_add32_ctrl.sv
// Self-checking bench for serial_add32_ctrl: directed vectors with literal
// expectations plus randomized operations checked every cycle against a
// behavioural model (arithmetic result + cycle countdown).
module tb_serial_add32_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         reset, start, sub;
  logic [W-1:0] a, b, sum;
  logic         busy, done, co;

  always #5 clk = ~clk;

  serial_add32_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_run, m_done, m_co, m_rco, sub_eff;
  int           m_left;
  logic [W-1:0] m_sum, m_res;
  logic [W:0]   m_r;

  always @(posedge clk) begin
`ifdef SERIAL_SUB_EN
    sub_eff = sub;
`else
    sub_eff = 1'b0;
`endif
    if (reset) begin
      m_run = 0; m_done = 0; m_sum = '0; m_co = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 0; m_done = 1; m_sum = m_res; m_co = m_rco;
      end
    end else if (start) begin
      if (sub_eff) m_r = {1'b0, a} + {1'b0, ~b} + 1;
      else         m_r = {1'b0, a} + {1'b0, b};
      m_res = m_r[W-1:0]; m_rco = m_r[W];
      m_run = 1; m_left = NBYTES; m_sum = '0; m_co = 0;
    end
  end

  // Per-cycle compare; sum/co are unqualified while the operation runs.
  always @(negedge clk) begin
    chk("busy", W'(busy), W'(m_run || m_done));
    chk("done", W'(done), W'(m_done));
    if (!m_run) begin
      chk("sum", sum, m_sum);
      chk("co",  W'(co), W'(m_co));
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: quiet inputs during run; 1: random junk incl. start; 2: start with a=b=0
  task automatic go(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss,
                    input int mode, output int edges, output logic [W-1:0] rs,
                    output logic rco);
    int n;
    n = 0;
    while ((m_run || m_done) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    start = 1'b1; a = aa; b = bb; sub = ss;
    @(posedge clk); #1;
    edges = 20; rs = 'x; rco = 1'bx;
    for (n = 1; n < 20; n++) begin
      if (n > 1 && done) begin
        edges = n; rs = sum; rco = co;
        break;
      end
      case (mode)
        1: begin start = 1'($urandom); a = $urandom; b = $urandom; sub = 1'($urandom); end
        2: begin start = 1'b1; a = '0; b = '0; end
        default: begin start = 1'b0; a = '0; b = '0; end
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (edges == 20) chk("done_timeout", W'(0), W'(1));
  endtask

  int           e;
  logic [W-1:0] rs;
  logic         rco;

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_sum",  sum, 32'h0000_0000);
    chk("rst_co",   W'(co), W'(0));
    reset = 1'b0;

    go(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, e, rs, rco);
    chk("basic_edge", W'(e), W'(5));
    chk("basic_sum",  rs, 32'h0000_0100);
    chk("basic_co",   W'(rco), W'(0));

    go(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, e, rs, rco);
    chk("wrap_sum", rs, 32'h0000_0000);
    chk("wrap_co",  W'(rco), W'(1));

    go(32'h1234_5678, 32'h1111_1111, 1'b0, 2, e, rs, rco);
    chk("ign_sum",  rs, 32'h2345_6789);
    chk("ign_edge", W'(e), W'(5));
    @(posedge clk); #1;
    chk("ign_single_done", W'(done), W'(0));
    chk("ign_idle",        W'(busy), W'(0));

    // Abort: reset sampled on the edge ending the 2nd RUN cycle.
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0101_0101;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_sum",  sum, 32'h0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_nodone", W'(done), W'(0));
    end
    go(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 0, e, rs, rco);
    chk("post_abort_sum", rs, 32'h0000_0000);
    chk("post_abort_co",  W'(rco), W'(1));

`ifdef SERIAL_SUB_EN
    go(32'd5, 32'd7, 1'b1, 0, e, rs, rco);
    chk("sub_neg_sum", rs, 32'hFFFF_FFFE);
    chk("sub_neg_co",  W'(rco), W'(0));
    go(32'd7, 32'd5, 1'b1, 0, e, rs, rco);
    chk("sub_pos_sum", rs, 32'h0000_0002);
    chk("sub_pos_co",  W'(rco), W'(1));
`endif

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        start = 1'b1; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end
      go($urandom, $urandom, 1'($urandom), $urandom_range(0, 2), e, rs, rco);
      chk("rand_edge", W'(e), W'(NBYTES + 1));
      chk("rand_sum",  rs, m_sum);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/serial_add32_ctrl.md
SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4: number of 8-bit slices per operand; operand width W = 8*NBYTES.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request to begin an addition.
REQ-005 SHALL have port a, input, W: first operand.
REQ-006 SHALL have port b, input, W: second operand.
REQ-007 SHALL have port sub, input, 1: subtract request; present only when SERIAL_SUB_EN is defined.
REQ-008 SHALL have port busy, output, 1: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum, output, W: result, held until the next accepted start.
REQ-011 SHALL have port co, output, 1: final carry-out, held with sum.

Function
REQ-012 SHALL share one 8-bit ripple adder slice across all bytes, processing one byte per cycle, LSB byte first.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE->RUN when start=1.
- RUN->DONE after byte NBYTES-1 is written.
- DONE->IDLE unconditionally.
REQ-014 SHALL sample start only in IDLE, and on acceptance latch a, b (and sub) into internal registers, clear the byte counter, and load carry-in 0 (1 when subtracting).
REQ-015 SHALL ignore start in RUN and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-016 SHALL, in RUN byte i, write the slice sum into sum[8i+7:8i] and register the slice carry as carry-in for byte i+1.
REQ-017 SHALL drive busy=1 exactly in RUN and DONE.
REQ-018 SHALL assert done for one cycle in DONE, NBYTES+1 rising edges after the edge that accepted start.
REQ-019 SHALL set co to the carry out of byte NBYTES-1 when entering DONE.
REQ-020 SHALL clear sum on acceptance; intermediate sum values during RUN SHALL be partial and unqualified.
REQ-021 SHALL produce modulo-2^W results; overflow is reported only through co.
REQ-022 SHALL use a byte counter of width clog2(NBYTES) (minimum 1) and SHALL NOT wrap it within RUN.

Reset
REQ-023 SHALL, when reset=1 at a rising edge, force IDLE with busy=0, done=0, sum=0, co=0, and counter and carry cleared.
REQ-024 SHALL give reset priority over start; reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-025 SHALL, with SERIAL_SUB_EN defined, compute a-b when sub=1: invert b per byte and set initial carry-in to 1; co=1 means no borrow.
REQ-026 SHALL, without SERIAL_SUB_EN, omit the sub port and logic and perform addition only.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the slice width constant (8) in a shared package.
REQ-028 SHALL instantiate one sub-module, add8_slice: an 8-bit combinational adder with carry-in and carry-out.

Verification
REQ-029 SHALL cover reset: hold reset for 2 cycles -> busy=0, done=0, sum=0x00000000, co=0.
REQ-030 SHALL cover a basic add: a=0x000000FF, b=0x00000001, start -> done on the 5th edge, sum=0x00000100, co=0.
REQ-031 SHALL cover wrap-around: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, co=1.
REQ-032 SHALL cover ignored start: start with a=0x12345678, b=0x11111111, then start with a=0, b=0 during RUN -> single done, sum=0x23456789.
REQ-033 SHALL cover reset mid-operation: reset in the 2nd RUN cycle -> IDLE, sum=0, no done pulse; a subsequent start works normally.
REQ-034 SHALL cover subtraction (SERIAL_SUB_EN): a=5, b=7, sub=1 -> sum=0xFFFFFFFE, co=0; a=7, b=5 -> sum=0x00000002, co=1.
